// File: rtl/lzd_pkg.sv
// Shared constants and types for the sequential 48-bit leading-zero normalizer.
package lzd_pkg;

    localparam int DATA_W = 48;
    localparam int SEG_W  = 16;
    localparam int NSEG   = 3;
    localparam int CNT_W  = 6;

    typedef logic [1:0] seg_idx_t;

    localparam seg_idx_t SEG_LAST = seg_idx_t'(NSEG - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/lzd_norm_seq_if.sv
// Operand/result handshake bundle for lzd_norm_seq.
interface lzd_norm_seq_if
    import lzd_pkg::*;
();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_lz;
    logic              out_zero;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_lz, out_zero
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_lz, out_zero
    );

endinterface

// File: rtl/lzd_16bit.sv
// Combinational 16-bit leading-zero detector, built as a 4 -> 8 -> 16 bit tree.
module lzd_16bit (
    input  logic [15:0] in,
    output logic [3:0]  out,
    output logic        valid
);

    logic [3:0] v4;
    logic [1:0] c4 [4];
    logic [1:0] v8;
    logic [2:0] c8 [2];
    logic [3:0] nib;

    always_comb begin
        nib = '0;
        // Index 0 is the most significant nibble / byte at every level.
        for (int unsigned i = 0; i < 4; i++) begin
            nib   = in[15 - 4*i -: 4];
            v4[i] = |nib;
            c4[i] = nib[3] ? 2'd0 : nib[2] ? 2'd1 : nib[1] ? 2'd2 : 2'd3;
        end
        for (int unsigned j = 0; j < 2; j++) begin
            v8[j] = v4[2*j] | v4[2*j+1];
            c8[j] = v4[2*j] ? {1'b0, c4[2*j]} : {1'b1, c4[2*j+1]};
        end
        valid = v8[0] | v8[1];
        out   = v8[0] ? {1'b0, c8[0]} : {1'b1, c8[1]};
    end

endmodule

// File: rtl/lzd_norm_seq.sv
// Sequential 48-bit normalizer: scans 16-bit segments MSB-first through one shared
// LZD, then left-shifts the operand so its MSB is set and reports the shift count.
module lzd_norm_seq
    import lzd_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    lzd_norm_seq_if.slave  bus
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] op_q, op_d;
    seg_idx_t          seg_q, seg_d;
    logic [CNT_W-1:0]  lz_q, lz_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_lz_q, out_lz_d;
    logic              out_zero_q, out_zero_d;

    logic [SEG_W-1:0]  seg_data;
    logic [3:0]        seg_lz;
    logic              seg_valid;

    assign seg_data = SEG_W'(op_q >> (SEG_W * (SEG_LAST - seg_q)));

    lzd_16bit u_lzd (
        .in    (seg_data),
        .out   (seg_lz),
        .valid (seg_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            seg_q      <= '0;
            lz_q       <= '0;
            out_data_q <= '0;
            out_lz_q   <= '0;
            out_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            seg_q      <= seg_d;
            lz_q       <= lz_d;
            out_data_q <= out_data_d;
            out_lz_q   <= out_lz_d;
            out_zero_q <= out_zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.in_valid) state_d = SCAN;
            SCAN: begin
                if (seg_valid)              state_d = SHIFT;
                else if (seg_q == SEG_LAST) state_d = DONE;
            end
            SHIFT: state_d = DONE;
            DONE:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d       = op_q;
        seg_d      = seg_q;
        lz_d       = lz_q;
        out_data_d = out_data_q;
        out_lz_d   = out_lz_q;
        out_zero_d = out_zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d  = bus.in_data;
                    seg_d = '0;
                    lz_d  = '0;
                end
            end
            SCAN: begin
                if (seg_valid) begin
                    lz_d = lz_q + CNT_W'(seg_lz);
                end else if (seg_q != SEG_LAST) begin
                    lz_d  = lz_q + CNT_W'(SEG_W);
                    seg_d = seg_q + seg_idx_t'(1);
                end else begin
                    // All segments empty: result is committed here, SHIFT is skipped.
                    out_data_d = '0;
                    out_lz_d   = CNT_W'(DATA_W);
                    out_zero_d = 1'b1;
                end
            end
            SHIFT: begin
                out_data_d = op_q << lz_q;
                out_lz_d   = lz_q;
                out_zero_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE) && !rst;
        bus.out_valid = (state_q == DONE);
        bus.out_data  = out_data_q;
        bus.out_lz    = out_lz_q;
        bus.out_zero  = out_zero_q;
    end

endmodule

// File: tb/tb_lzd_norm_seq.sv
// Self-checking bench for lzd_norm_seq: directed vectors, back-pressure, mid-op reset
// and randomized operands against a bit-scan reference model.
module tb_lzd_norm_seq;
    import lzd_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lzd_norm_seq_if bus ();

    lzd_norm_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    function automatic int ref_lz(input logic [47:0] d);
        for (int i = 47; i >= 0; i--)
            if (d[i]) return 47 - i;
        return 48;
    endfunction

    function automatic int ref_lat(input int lz);
        return (lz == 48) ? 3 : (lz / 16) + 2;
    endfunction

    // Offers one operand and waits for its result; drains it if out_ready is high.
    task automatic do_op(input logic [47:0] d, output logic [47:0] q, output int lz,
                         output logic z, output int lat, output logic to);
        to = 1'b0; lat = 0; q = '0; lz = 0; z = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int n = 0; n < 20 && !bus.in_ready; n++) begin
            @(posedge clk); #1;
        end
        if (!bus.in_ready) begin
            to = 1'b1;
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 48'({$urandom(), $urandom()});
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            to = 1'b1;
            return;
        end
        q  = bus.out_data;
        lz = int'(bus.out_lz);
        z  = bus.out_zero;
        if (bus.out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 48'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        checks++; if (bus.out_lz !== 6'd0) begin failures++; $display("FAIL reset_out_lz got=%0d exp=0", bus.out_lz); end
        checks++; if (bus.out_zero !== 1'b0) begin failures++; $display("FAIL reset_out_zero got=%b exp=0", bus.out_zero); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [47:0] vec [5];
        logic [47:0] q;
        int lz, lat;
        logic z, to;
        vec[0] = 48'h8000_0000_0000;
        vec[1] = 48'h0000_0001_0000;
        vec[2] = 48'h0000_0000_0001;
        vec[3] = 48'h0000_0000_0F0F;
        vec[4] = 48'h0000_0000_0000;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_op(vec[i], q, lz, z, lat, to);
            checks++; if (to) begin failures++; $display("FAIL dir_timeout vec=%h got=timeout exp=result", vec[i]); end
            checks++; if (q !== (vec[i] << ref_lz(vec[i]))) begin failures++; $display("FAIL dir_data vec=%h got=%h exp=%h", vec[i], q, vec[i] << ref_lz(vec[i])); end
            checks++; if (lz != ref_lz(vec[i])) begin failures++; $display("FAIL dir_lz vec=%h got=%0d exp=%0d", vec[i], lz, ref_lz(vec[i])); end
            checks++; if (z !== (vec[i] == 48'h0)) begin failures++; $display("FAIL dir_zero vec=%h got=%b exp=%b", vec[i], z, vec[i] == 48'h0); end
            checks++; if (lat != ref_lat(ref_lz(vec[i]))) begin failures++; $display("FAIL dir_latency vec=%h got=%0d exp=%0d", vec[i], lat, ref_lat(ref_lz(vec[i]))); end
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] d1, d2, q;
        int lz, lat;
        logic z, to;
        d1 = 48'h0000_0234_5678;
        d2 = 48'h0003_0000_0000;
        bus.out_ready = 1'b0;
        do_op(d1, q, lz, z, lat, to);
        checks++; if (to) begin failures++; $display("FAIL bp_timeout got=timeout exp=result"); end
        checks++; if (lz != ref_lz(d1)) begin failures++; $display("FAIL bp_lz got=%0d exp=%0d", lz, ref_lz(d1)); end
        bus.in_valid = 1'b1;
        bus.in_data  = d2;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", c, bus.out_valid); end
            checks++; if (bus.out_data !== (d1 << ref_lz(d1))) begin failures++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=%h", c, bus.out_data, d1 << ref_lz(d1)); end
            checks++; if (int'(bus.out_lz) != ref_lz(d1)) begin failures++; $display("FAIL bp_hold_lz cyc=%0d got=%0d exp=%0d", c, bus.out_lz, ref_lz(d1)); end
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
        do_op(d2, q, lz, z, lat, to);
        checks++; if (to) begin failures++; $display("FAIL bp_next_timeout got=timeout exp=result"); end
        checks++; if (q !== (d2 << ref_lz(d2))) begin failures++; $display("FAIL bp_next_data got=%h exp=%h", q, d2 << ref_lz(d2)); end
        checks++; if (lz != ref_lz(d2)) begin failures++; $display("FAIL bp_next_lz got=%0d exp=%0d", lz, ref_lz(d2)); end
    endtask

    task automatic test_reset_mid();
        logic [47:0] q;
        int lz, lat;
        logic z, to, seen;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 48'h0000_0000_0001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=0", bus.in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_after_in_ready got=%b exp=1", bus.in_ready); end
        seen = bus.out_valid;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | bus.out_valid;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_valid got=%b exp=0", seen); end
        do_op(48'h4000_0000_0000, q, lz, z, lat, to);
        checks++; if (to) begin failures++; $display("FAIL mid_next_timeout got=timeout exp=result"); end
        checks++; if (lz != 1) begin failures++; $display("FAIL mid_next_lz got=%0d exp=1", lz); end
        checks++; if (q !== 48'h8000_0000_0000) begin failures++; $display("FAIL mid_next_data got=%h exp=800000000000", q); end
    endtask

    task automatic test_random();
        logic [47:0] d, q;
        int lz, lat, hold;
        logic z, to;
        for (int i = 0; i < 60; i++) begin
            d = 48'({$urandom(), $urandom()}) >> $urandom_range(0, 48);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            do_op(d, q, lz, z, lat, to);
            checks++; if (to) begin failures++; $display("FAIL rnd_timeout d=%h got=timeout exp=result", d); end
            checks++; if (q !== (d << ref_lz(d))) begin failures++; $display("FAIL rnd_data d=%h got=%h exp=%h", d, q, d << ref_lz(d)); end
            checks++; if (lz != ref_lz(d)) begin failures++; $display("FAIL rnd_lz d=%h got=%0d exp=%0d", d, lz, ref_lz(d)); end
            checks++; if (z !== (d == 48'h0)) begin failures++; $display("FAIL rnd_zero d=%h got=%b exp=%b", d, z, d == 48'h0); end
            checks++; if (lat != ref_lat(ref_lz(d))) begin failures++; $display("FAIL rnd_latency d=%h got=%0d exp=%0d", d, lat, ref_lat(ref_lz(d))); end
            if (!bus.out_ready) begin
                hold = $urandom_range(1, 4);
                repeat (hold) begin
                    @(posedge clk); #1;
                    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== (d << ref_lz(d))) begin
                        failures++; $display("FAIL rnd_stall d=%h got_valid=%b got_data=%h exp_data=%h", d, bus.out_valid, bus.out_data, d << ref_lz(d));
                    end
                end
                bus.out_ready = 1'b1;
                @(posedge clk); #1;
                checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rnd_drain d=%h got=%b exp=0", d, bus.out_valid); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
